// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode field constants and the immediate format tag.
package legv8_pkg;

  localparam logic [5:0]  B_OP     = 6'b000101;
  localparam logic [5:0]  BL_OP    = 6'b100101;
  localparam logic [7:0]  CBZ_OP   = 8'b10110100;
  localparam logic [7:0]  CBNZ_OP  = 8'b10110101;
  localparam logic [7:0]  BCOND_OP = 8'b01010100;
  localparam logic [10:0] LDUR_OP  = 11'b11111000010;
  localparam logic [10:0] STUR_OP  = 11'b11111000000;
  localparam logic [8:0]  MOVZ_OP  = 9'b110100101;
  localparam logic [8:0]  MOVK_OP  = 9'b111100101;
  localparam logic [9:0]  ADDI_OP  = 10'b1001000100;
  localparam logic [9:0]  SUBI_OP  = 10'b1101000100;
  localparam logic [10:0] LSL_OP   = 11'b11010011011;
  localparam logic [10:0] LSR_OP   = 11'b11010011010;

  typedef enum logic [2:0] {
    FmtUnk = 3'd0,
    FmtB   = 3'd1,
    FmtCb  = 3'd2,
    FmtD   = 3'd3,
    FmtI   = 3'd4,
    FmtIm  = 3'd5,
    FmtSh  = 3'd6
  } fmt_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int unsigned DATA_W = 64
);
  import legv8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] extended;
  fmt_t              fmt;

  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, extended, fmt
  );

  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, extended, fmt
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational LEGv8 instruction classifier and immediate extender.
module imm_decode
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter bit          BR_SHIFT = 1'b0
) (
  input  logic [31:0]       instr_i,
  output logic [DATA_W-1:0] imm_o,
  output fmt_t              fmt_o
);

  always_comb begin
    fmt_o = FmtUnk;
    imm_o = '0;
    if (instr_i[31:26] == B_OP || instr_i[31:26] == BL_OP) begin
      fmt_o = FmtB;
      imm_o = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]};
    end else if (instr_i[31:24] == CBZ_OP || instr_i[31:24] == CBNZ_OP ||
                 instr_i[31:24] == BCOND_OP) begin
      fmt_o = FmtCb;
      imm_o = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
    end else if (instr_i[31:21] == LDUR_OP || instr_i[31:21] == STUR_OP) begin
      fmt_o = FmtD;
      imm_o = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
    end else if (instr_i[31:23] == MOVZ_OP || instr_i[31:23] == MOVK_OP) begin
      fmt_o = FmtIm;
      // Shifting past the top clears the value, which covers hw>=2 at 32 bits.
      imm_o = DATA_W'(instr_i[20:5]) << {instr_i[22:21], 4'b0000};
    end else if (instr_i[31:22] == ADDI_OP || instr_i[31:22] == SUBI_OP) begin
      fmt_o = FmtI;
      imm_o = DATA_W'(instr_i[21:10]);
    end else if (instr_i[31:21] == LSL_OP || instr_i[31:21] == LSR_OP) begin
      fmt_o = FmtSh;
      imm_o = DATA_W'(instr_i[15:10]);
    end

    if (BR_SHIFT && (fmt_o == FmtB || fmt_o == FmtCb)) begin
      imm_o = imm_o << 2;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with a small output buffer behind valid/ready.
module imm_gen_pipe
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter bit          BR_SHIFT = 1'b0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] dec_imm;
  fmt_t              dec_fmt;

  logic [DATA_W-1:0] imm_q [DEPTH];
  fmt_t              fmt_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              push, pop;

  imm_decode #(
    .DATA_W   (DATA_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_imm_decode (
    .instr_i (bus.instruction),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // in_ready depends on registered count only, so out_ready never reaches it.
  assign bus.in_ready  = cnt_q < CntW'(DEPTH);
  assign bus.out_valid = cnt_q != '0;
  assign bus.extended  = imm_q[rd_ptr_q];
  assign bus.fmt       = fmt_q[rd_ptr_q];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FmtUnk;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !flush) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: scoreboard queue fed at push, checked at the head.
module tb_imm_gen_pipe;
  import legv8_pkg::*;

  typedef struct packed {
    logic [63:0] ext;
    logic [2:0]  fmt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  imm_gen_pipe_if #(.DATA_W(64)) bus0 ();
  imm_gen_pipe_if #(.DATA_W(64)) bus1 ();

  imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(1'b0), .DEPTH(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus0)
  );

  imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(1'b1), .DEPTH(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference for the immediate, independent of the RTL bit-concatenation form.
  function automatic void ref_decode(input logic [31:0] w, input bit brs,
                                     output logic [63:0] e, output logic [2:0] f);
    logic [63:0] v;
    v = 64'd0;
    f = 3'd0;
    if (w[31:26] == 6'h05 || w[31:26] == 6'h25) begin
      f = 3'd1; v = 64'(w[25:0]); if (w[25]) v = v - (64'd1 << 26);
    end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
      f = 3'd2; v = 64'(w[23:5]); if (w[23]) v = v - (64'd1 << 19);
    end else if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      f = 3'd3; v = 64'(w[20:12]); if (w[20]) v = v - 64'd512;
    end else if (w[31:23] == 9'h1A5 || w[31:23] == 9'h1E5) begin
      f = 3'd5; v = 64'(w[20:5]) * (64'd1 << (16 * w[22:21]));
    end else if (w[31:22] == 10'h244 || w[31:22] == 10'h344) begin
      f = 3'd4; v = 64'(w[21:10]);
    end else if (w[31:21] == 11'h69B || w[31:21] == 11'h69A) begin
      f = 3'd6; v = 64'(w[15:10]);
    end
    if (brs && (f == 3'd1 || f == 3'd2)) v = v * 64'd4;
    e = v;
  endfunction

  // Advance one clock and track dut0 in the scoreboard.
  task automatic tick();
    bit   do_push, do_pop;
    exp_t e;
    do_push = bus0.in_valid && exp_q.size() < 2 && !flush && rst_n;
    do_pop  = exp_q.size() != 0 && bus0.out_ready && !flush && rst_n;
    e = '0;
    if (do_push) ref_decode(bus0.instruction, 1'b0, e.ext, e.fmt);
    @(posedge clk);
    #1;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %0b want 1", bus0.in_ready); end
    checks++; if (bus0.extended !== 64'd0) begin errors++;
      $display("FAIL reset_extended: got %h want 0", bus0.extended); end
    checks++; if (bus0.fmt !== 3'd0) begin errors++;
      $display("FAIL reset_fmt: got %0d want 0", bus0.fmt); end
  endtask

  task automatic test_spec_vectors();
    logic [31:0] words [5] = '{32'hF85F8041, 32'h17FFFFFF, 32'hD2C24680, 32'hD3401420,
                               32'h00000000};
    logic [63:0] want_e [5] = '{64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFF,
                                64'h0000123400000000, 64'd5, 64'd0};
    logic [2:0]  want_f [5] = '{3'd3, 3'd1, 3'd5, 3'd6, 3'd0};
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid    = 1'b1;
      bus0.instruction = words[i];
      tick();
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b1) begin errors++;
        $display("FAIL vec%0d_out_valid: got %0b want 1", i, bus0.out_valid); end
      checks++; if (bus0.fmt !== want_f[i]) begin errors++;
        $display("FAIL vec%0d_fmt: got %0d want %0d", i, bus0.fmt, want_f[i]); end
      checks++; if (bus0.extended !== want_e[i]) begin errors++;
        $display("FAIL vec%0d_extended: got %h want %h", i, bus0.extended, want_e[i]); end
      tick();
    end
  endtask

  task automatic test_formats();
    logic [31:0] words [12] = '{32'h94000010, 32'hB4FFFFE0, 32'h54000101, 32'hF8010020,
                                32'h91000420, 32'hD1003C00, 32'hF2A00020, 32'hD3600C00,
                                32'hD3000000, 32'hFFFFFFFF, 32'hB5800000, 32'hF2E0FFE0};
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus0.in_valid    = 1'b1;
      bus0.instruction = words[i];
      tick();
      bus0.in_valid    = 1'b0;
      bus0.instruction = 32'h17FFFFFF;
      checks++;
      if (exp_q.size() == 0) begin errors++;
        $display("FAIL fmt%0d_scoreboard: got empty want 1 entry", i);
      end else if (bus0.out_valid !== 1'b1 || bus0.extended !== exp_q[0].ext ||
                   bus0.fmt !== exp_q[0].fmt) begin errors++;
        $display("FAIL fmt%0d_word %h: got v=%0b e=%h f=%0d want v=1 e=%h f=%0d", i,
                 words[i], bus0.out_valid, bus0.extended, bus0.fmt, exp_q[0].ext, exp_q[0].fmt);
      end
      tick();
    end
  endtask

  task automatic test_br_shift();
    logic [31:0] words [2] = '{32'h17FFFFFF, 32'h54000101};
    logic [63:0] want_e [2] = '{64'hFFFFFFFFFFFFFFFC, 64'd32};
    logic [2:0]  want_f [2] = '{3'd1, 3'd2};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus1.in_valid    = 1'b1;
      bus1.instruction = words[i];
      tick();
      bus1.in_valid = 1'b0;
      checks++; if (bus1.out_valid !== 1'b1 || bus1.extended !== want_e[i] ||
                    bus1.fmt !== want_f[i]) begin errors++;
        $display("FAIL brshift%0d: got v=%0b e=%h f=%0d want v=1 e=%h f=%0d", i,
                 bus1.out_valid, bus1.extended, bus1.fmt, want_e[i], want_f[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus0.out_ready   = 1'b0;
    bus0.in_valid    = 1'b1;
    bus0.instruction = 32'hF85F8041;
    tick();
    checks++; if (bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ready_after_1: got %0b want 1", bus0.in_ready); end
    bus0.instruction = 32'hD3401420;
    tick();
    checks++; if (bus0.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_ready_after_2: got %0b want 0", bus0.in_ready); end
    bus0.instruction = 32'h91000420;
    tick();
    tick();
    bus0.in_valid = 1'b0;
    checks++; if (exp_q.size() != 2 || bus0.extended !== 64'hFFFFFFFFFFFFFFF8 ||
                  bus0.fmt !== 3'd3) begin errors++;
      $display("FAIL bp_head_held: got e=%h f=%0d q=%0d want e=fffffffffffffff8 f=3 q=2",
               bus0.extended, bus0.fmt, exp_q.size()); end
    bus0.out_ready = 1'b1;
    tick();
    checks++; if (bus0.in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_ready_after_pop: got %0b want 1", bus0.in_ready); end
    checks++; if (bus0.out_valid !== 1'b1 || bus0.fmt !== 3'd6 || bus0.extended !== 64'd5)
    begin errors++;
      $display("FAIL bp_second: got v=%0b e=%h f=%0d want v=1 e=5 f=6",
               bus0.out_valid, bus0.extended, bus0.fmt); end
    tick();
    checks++; if (bus0.out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drained: got %0b want 0 (third word must be dropped)",
               bus0.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4] = '{32'h94000010, 32'hD2C24680, 32'hF8010020, 32'hD3600C00};
    bus0.out_ready   = 1'b0;
    bus0.in_valid    = 1'b1;
    bus0.instruction = 32'h91000420;
    tick();
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.instruction = words[i];
      checks++;
      if (exp_q.size() != 1) begin errors++;
        $display("FAIL b2b%0d_count: got %0d want 1", i, exp_q.size());
      end else if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b1 ||
                   bus0.extended !== exp_q[0].ext || bus0.fmt !== exp_q[0].fmt) begin errors++;
        $display("FAIL b2b%0d: got v=%0b r=%0b e=%h f=%0d want v=1 r=1 e=%h f=%0d", i,
                 bus0.out_valid, bus0.in_ready, bus0.extended, bus0.fmt,
                 exp_q[0].ext, exp_q[0].fmt);
      end
      tick();
    end
    bus0.in_valid = 1'b0;
    checks++; if (bus0.out_valid !== 1'b1 || bus0.extended !== 64'd3 || bus0.fmt !== 3'd6)
    begin errors++;
      $display("FAIL b2b_last: got v=%0b e=%h f=%0d want v=1 e=3 f=6",
               bus0.out_valid, bus0.extended, bus0.fmt); end
    tick();
  endtask

  task automatic test_flush_and_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus0.out_ready   = 1'b0;
      bus0.in_valid    = 1'b1;
      bus0.instruction = 32'hF85F8041;
      tick();
      bus0.instruction = 32'hD2C24680;
      tick();
      bus0.instruction = 32'hD3401420;
      if (pass == 0) flush = 1'b1; else rst_n = 1'b0;
      tick();
      flush    = 1'b0;
      rst_n    = 1'b1;
      bus0.in_valid = 1'b0;
      checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin errors++;
        $display("FAIL clear%0d_state: got v=%0b r=%0b want v=0 r=1", pass,
                 bus0.out_valid, bus0.in_ready); end
      if (pass == 1) begin
        checks++; if (bus0.extended !== 64'd0 || bus0.fmt !== 3'd0) begin errors++;
          $display("FAIL clear1_outputs: got e=%h f=%0d want e=0 f=0",
                   bus0.extended, bus0.fmt); end
      end
      // in_valid=0 with a live opcode on the bus must not push.
      tick();
      checks++; if (bus0.out_valid !== 1'b0) begin errors++;
        $display("FAIL clear%0d_word_lost: got %0b want 0", pass, bus0.out_valid); end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    flush            = 1'b0;
    bus0.in_valid    = 1'b0;
    bus0.out_ready   = 1'b0;
    bus0.instruction = 32'd0;
    bus1.in_valid    = 1'b0;
    bus1.out_ready   = 1'b0;
    bus1.instruction = 32'd0;
    test_reset();
    test_spec_vectors();
    test_formats();
    test_br_shift();
    test_backpressure();
    test_back_to_back();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
